// File: rtl/video_vga_timing.sv
// Parametrised VGA timing generator: pixel/line/frame strobes, beam position,
// sync/blank pipeline matched to the palette latency, and registered VGA pins.
module video_vga_timing #(
  parameter int H_ACTIVE       = 640,
  parameter int H_FRONT_PORCH  = 16,
  parameter int H_SYNC         = 96,
  parameter int H_BACK_PORCH   = 48,
  parameter int V_ACTIVE       = 480,
  parameter int V_FRONT_PORCH  = 10,
  parameter int V_SYNC         = 2,
  parameter int V_BACK_PORCH   = 33,
  parameter bit HSYNC_POL      = 1'b0,
  parameter bit VSYNC_POL      = 1'b0,
  parameter int CLK_DIV        = 1,
  parameter int PIPE_DELAY     = 2,
  parameter int PREFETCH_LINES = 1,
  parameter int COLOR_W        = 4,
  localparam int H_TOTAL = H_ACTIVE + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH,
  localparam int V_TOTAL = V_ACTIVE + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH,
  localparam int XW      = $clog2(H_TOTAL),
  localparam int YW      = $clog2(V_TOTAL)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [3*COLOR_W-1:0]   palette_rgb_data,
  output logic                   next_pixel,
  output logic                   next_line,
  output logic                   next_frame,
  output logic                   vblank_pulse,
  output logic [XW-1:0]          beam_x,
  output logic [YW-1:0]          beam_y,
  output logic [15:0]            frame_cnt,
  output logic [COLOR_W-1:0]     vga_r,
  output logic [COLOR_W-1:0]     vga_g,
  output logic [COLOR_W-1:0]     vga_b,
  output logic                   vga_hsync,
  output logic                   vga_vsync
);

  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_clk_div
    $error("video_vga_timing: CLK_DIV must be 1..16");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_pipe_delay
    $error("video_vga_timing: PIPE_DELAY must be 0..7");
  end
  if (PREFETCH_LINES < 0 || PREFETCH_LINES > V_TOTAL - 1) begin : g_bad_prefetch
    $error("video_vga_timing: PREFETCH_LINES must be 0..V_TOTAL-1");
  end
  if (H_ACTIVE < 1 || V_ACTIVE < 1 || H_SYNC < 1 || V_SYNC < 1 || COLOR_W < 1 ||
      H_FRONT_PORCH < 0 || H_BACK_PORCH < 0 || V_FRONT_PORCH < 0 || V_BACK_PORCH < 0 ||
      H_TOTAL < 2 || V_TOTAL < 2) begin : g_bad_timing
    $error("video_vga_timing: illegal timing or colour width");
  end

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_FRAME  = YW'(V_TOTAL - 1 - PREFETCH_LINES);
  localparam logic [YW-1:0] Y_VBLANK = YW'(V_ACTIVE - 1);
  localparam int HS_START = H_ACTIVE + H_FRONT_PORCH;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FRONT_PORCH;
  localparam int VS_END   = VS_START + V_SYNC;

  logic [DW-1:0] div_cnt;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          h_last;
  logic          v_last;
  logic          hsync_raw;
  logic          vsync_raw;
  logic          active;
  logic [2:0]    raw;
  logic [2:0]    dly;

  // next_pixel is a clock enable, not a handshake: every clk edge where it is
  // high consumes exactly one pixel; downstream never stalls the generator.
  assign next_pixel = enable && (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (!enable || next_pixel) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  assign h_last = (x == X_LAST);
  assign v_last = (y == Y_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (!enable) begin
      x <= '0;
      y <= '0;
    end else if (next_pixel) begin
      if (h_last) begin
        x <= '0;
        y <= v_last ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  // frame_cnt survives a disable; only the async reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (next_pixel && h_last && v_last) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign beam_x       = x;
  assign beam_y       = y;
  assign next_line    = next_pixel && h_last;
  assign next_frame   = next_line && (y == Y_FRAME);
  assign vblank_pulse = next_line && (y == Y_VBLANK);

  assign hsync_raw = (int'(x) >= HS_START) && (int'(x) < HS_END);
  assign vsync_raw = (int'(y) >= VS_START) && (int'(y) < VS_END);
  assign active    = (int'(x) < H_ACTIVE) && (int'(y) < V_ACTIVE);
  assign raw       = {hsync_raw, vsync_raw, active};

  if (PIPE_DELAY == 0) begin : g_no_pipe
    assign dly = raw;
  end else begin : g_pipe
    logic [2:0] pipe_q [PIPE_DELAY];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < PIPE_DELAY; i++) pipe_q[i] <= '0;
      end else if (!enable) begin
        for (int i = 0; i < PIPE_DELAY; i++) pipe_q[i] <= '0;
      end else if (next_pixel) begin
        pipe_q[0] <= raw;
        for (int i = 1; i < PIPE_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign dly = pipe_q[PIPE_DELAY-1];
  end

  // dly = {hsync, vsync, active} for the pixel whose colour is arriving now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
      vga_hsync <= ~HSYNC_POL;
      vga_vsync <= ~VSYNC_POL;
    end else if (!enable) begin
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
      vga_hsync <= ~HSYNC_POL;
      vga_vsync <= ~VSYNC_POL;
    end else if (next_pixel) begin
      vga_r     <= dly[0] ? palette_rgb_data[3*COLOR_W-1 -: COLOR_W] : '0;
      vga_g     <= dly[0] ? palette_rgb_data[2*COLOR_W-1 -: COLOR_W] : '0;
      vga_b     <= dly[0] ? palette_rgb_data[COLOR_W-1 -: COLOR_W]   : '0;
      vga_hsync <= dly[2] ^ ~HSYNC_POL;
      vga_vsync <= dly[1] ^ ~VSYNC_POL;
    end
  end

endmodule
